// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a sync-read imem, feeds IF/ID with ir_out/pc_plus4.
// Latency: address issued in cycle N, instruction on ir_out in cycle N+1 (redirect has zero bubble).
// Backpressure: stall holds PC and ir_out (re-reads pc_q); halt parks the stage until resume.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    input  logic               halt,
    input  logic               resume,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        ir_out,
    output logic [31:0]        pc_out,
    output logic [31:0]        pc_plus4,
    output logic               valid_out,
    output logic               halted,
    output logic               misalign_err,
    output logic [31:0]        fetch_cnt
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Next address to issue, and the address whose data is on imem_rdata.
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_nxt;
    logic [31:0] pc_q;
    logic [31:0] pc_nxt;
    logic        valid_q;
    logic        valid_nxt;

    logic        misalign_q;
    logic        misalign_set;
    logic [31:0] fetch_cnt_q;
    logic        cnt_inc;

    // Redirect targets are forced word-aligned; the low bits only feed the error flag.
    logic [31:0] redirect_tgt;
    logic        in_run;

    assign redirect_tgt = {redirect_pc[31:2], 2'b00};
    assign in_run       = (state == ST_RUN);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: halt parks the stage, resume releases it; nothing else matters in HALT.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RUN: begin
                if (halt) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // FSM outputs: halt flag and the instruction-memory address mux.
    always_comb begin
        halted    = (state == ST_HALT);
        imem_addr = fetch_pc[IMEM_AW+1:2];
        if (in_run && redirect) begin
            imem_addr = redirect_tgt[IMEM_AW+1:2];
        end else if (in_run && stall) begin
            // Re-read the current instruction so ir_out stays stable next cycle.
            imem_addr = pc_q[IMEM_AW+1:2];
        end
    end

    // PC / valid next-value selection in RUN priority order: halt, redirect, stall, advance.
    always_comb begin
        fetch_pc_nxt = fetch_pc;
        pc_nxt       = pc_q;
        valid_nxt    = valid_q;
        misalign_set = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (halt) begin
                    // Instruction currently on ir_out is the last one delivered.
                    valid_nxt = 1'b0;
                end else if (redirect) begin
                    pc_nxt       = redirect_tgt;
                    fetch_pc_nxt = redirect_tgt + 32'd4;
                    valid_nxt    = 1'b1;
                    misalign_set = (redirect_pc[1:0] != 2'b00);
                end else if (stall) begin
                    valid_nxt = valid_q;
                end else begin
                    pc_nxt       = fetch_pc;
                    fetch_pc_nxt = fetch_pc + 32'd4;
                    valid_nxt    = 1'b1;
                end
            end
            ST_HALT: begin
                valid_nxt = 1'b0;
                if (resume) begin
                    // fetch_pc still points at the first undelivered instruction.
                    pc_nxt       = fetch_pc;
                    fetch_pc_nxt = fetch_pc + 32'd4;
                    valid_nxt    = 1'b1;
                end
            end
            default: begin
                valid_nxt = 1'b0;
            end
        endcase
    end

    // An instruction is delivered to decode whenever a valid one is presented without stall.
    assign cnt_inc = valid_q && !stall;

    // PC, valid and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            pc_q        <= RESET_PC;
            valid_q     <= 1'b0;
            misalign_q  <= 1'b0;
            fetch_cnt_q <= 32'd0;
        end else begin
            fetch_pc <= fetch_pc_nxt;
            pc_q     <= pc_nxt;
            valid_q  <= valid_nxt;
            if (misalign_set) begin
                misalign_q <= 1'b1;
            end
            if (cnt_inc) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
        end
    end

    // Output drive toward the IF/ID register.
    always_comb begin
        ir_out       = valid_q ? imem_rdata : 32'd0;
        pc_out       = pc_q;
        pc_plus4     = pc_q + 32'd4;
        valid_out    = valid_q;
        misalign_err = misalign_q;
        fetch_cnt    = fetch_cnt_q;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage pipeline. Sits directly upstream of the IF/ID pipeline register and feeds it `ir_out` and `pc_plus4`.
- Owns the PC register and drives a synchronous-read instruction memory (1-cycle read latency).
- Handles stall hold, branch/jump redirect and a halt/resume state machine.
- Counts instructions delivered to decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_AW, 10, instruction memory word-address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hazard stall; hold PC and output (same signal drives IF/ID hold)
- redirect  in  1  taken branch/jump this cycle
- redirect_pc  in  32  target address for redirect
- halt  in  1  halt request (syscall) from a later stage
- resume  in  1  leave HALT state
- imem_addr  out  IMEM_AW  word address to instruction memory (combinational)
- imem_rdata  in  32  instruction word; valid one cycle after address
- ir_out  out  32  fetched instruction; 0 (NOP) when not valid
- pc_out  out  32  address of the instruction on ir_out
- pc_plus4  out  32  pc_out + 4
- valid_out  out  1  ir_out holds a real instruction
- halted  out  1  FSM is in HALT
- misalign_err  out  1  sticky; a redirect target had bits [1:0] != 0
- fetch_cnt  out  32  instructions delivered to decode

Behaviour:
- Internal registers:
  - fetch_pc: next address to issue.
  - pc_q: address whose data is on imem_rdata.
  - valid_q.
  - state: RUN or HALT.
- Reset (rst=1 at posedge; overrides everything, including mid-stall, mid-halt and redirect):
  - fetch_pc=RESET_PC, pc_q=RESET_PC, valid_q=0, state=RUN, misalign_err=0, fetch_cnt=0.
  - Hence ir_out=0, valid_out=0, pc_out=RESET_PC and halted=0 after reset.
- Outputs:
  - ir_out = valid_q ? imem_rdata : 0.
  - pc_out = pc_q; pc_plus4 = pc_q+4 (mod 2^32); valid_out = valid_q; halted = (state==HALT).
- imem_addr = A[IMEM_AW+1:2], where A is selected in priority order:
  - RUN && redirect: A = redirect_pc & ~3
  - RUN && stall: A = pc_q, so imem_rdata re-presents the current instruction next cycle
  - otherwise: A = fetch_pc
- RUN state, per cycle, in priority order:
  1. halt: state<=HALT, valid_q<=0, fetch_pc and pc_q hold. The instruction currently on ir_out is the last one delivered.
  2. redirect: pc_q<=redirect_pc&~3, fetch_pc<=(redirect_pc&~3)+4, valid_q<=1. Target instruction appears on ir_out next cycle (zero fetch bubble). If redirect_pc[1:0]!=0, set misalign_err<=1. Redirect wins over stall in the same cycle.
  3. stall: fetch_pc, pc_q and valid_q hold; ir_out is stable across the stall.
  4. else: pc_q<=fetch_pc, fetch_pc<=fetch_pc+4, valid_q<=1.
- HALT state:
  - stall, redirect and halt are ignored; valid_q stays 0; imem_addr=fetch_pc.
  - resume: state<=RUN, pc_q<=fetch_pc, fetch_pc<=fetch_pc+4, valid_q<=1. Execution continues at the first undelivered instruction.
- fetch_cnt:
  - Increments (mod 2^32) in any cycle with valid_out=1 and stall=0, regardless of redirect or halt in that cycle.
  - Never increments while stall=1 or in HALT.
- Wrap-around: fetch_pc 32'hFFFF_FFFC + 4 = 0. imem_addr wraps naturally within 2^IMEM_AW words.
- Latency: address issued at cycle N → instruction on ir_out at cycle N+1.

Test Plan:
- Reset then run 4 cycles with imem[i]=0x1000_0000+i → ir_out shows 0, then 0x1000_0000..0x1000_0002; pc_out 0,0,4,8; fetch_cnt=3 after cycle 4.
- Stall for 3 cycles while ir_out=inst@0x8 → ir_out, pc_out=0x8 and fetch_cnt frozen. Release → next ir_out is inst@0xC; no instruction skipped or duplicated.
- Redirect to 0x40 with stall=1 in the same cycle → next cycle pc_out=0x40, ir_out=imem[16], then 0x44. Redirect to 0x43 → pc_out=0x40 and misalign_err=1, staying 1 until rst.
- halt while pc_out=0x10 → next cycle valid_out=0, halted=1. Redirect/stall during HALT ignored. resume → ir_out=inst@0x14, pc_out=0x14.
- Assert rst during HALT with fetch_cnt=7 → next cycle halted=0, valid_out=0, pc_out=RESET_PC, fetch_cnt=0.
- Redirect to 0xFFFF_FFFC, then advance → pc_out 0xFFFF_FFFC then 0x0; pc_plus4 at 0xFFFF_FFFC reads 0x0.
